mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port unified memory between the 17-bit mips core's instruction-fetch port and its data port. It sits between the core (`pc`/`instr`, `aluout`/`writedata`/`readdata`/`memwrite`) and the memory. It serialises accesses with round-robin fairness and returns per-requester ready pulses that the core uses as stall releases. A watchdog aborts any memory access that never acknowledges.

---
 rtl/mips_pkg.sv | 19 +
 rtl/rr_pick2.sv | 16 +
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the mips core memory arbiter.
package mips_pkg;

    localparam int AW_DEF      = 17;
    localparam int DW_DEF      = 17;
    localparam int TIMEOUT_DEF = 15;

    // Watchdog counter width; wide enough for the largest legal TIMEOUT (255).
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module rr_pick2 (
    input  logic req_i,
    input  logic req_d,
    input  logic last_d,
    output logic gnt_i,
    output logic gnt_d
);

    // Combinational grant; at most one grant is ever high.
    always_comb begin
        gnt_i = req_i & (~req_d | last_d);
        gnt_d = req_d & (~req_i | ~last_d);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no access in flight; pick a requester
// ST_BUSY_I | fetch access on the memory bus, watchdog running
// ST_BUSY_D | data access on the memory bus, watchdog running
// ST_RESP_I | one-cycle if_ready pulse (err valid alongside)
// ST_RESP_D | one-cycle d_ready pulse (err valid alongside)
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_d;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             gnt_i;
    logic             gnt_d;
    logic             grant_i;
    logic             grant_d;
    logic             tmo_hit;
    logic             done_i;
    logic             done_d;

    rr_pick2 u_pick (
        .req_i  (if_req),
        .req_d  (d_req),
        .last_d (last_d),
        .gnt_i  (gnt_i),
        .gnt_d  (gnt_d)
    );

    // An ack arriving in the terminal-count cycle still wins over the abort.
    assign tmo_hit = (cnt == TMO) && !mem_ack;

    // Next-state decode and per-transition strobes.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        done_i    = 1'b0;
        done_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_i) begin
                    state_nxt = ST_BUSY_I;
                    grant_i   = 1'b1;
                end else if (gnt_d) begin
                    state_nxt = ST_BUSY_D;
                    grant_d   = 1'b1;
                end
            end
            ST_BUSY_I: begin
                if (mem_ack || tmo_hit) begin
                    state_nxt = ST_RESP_I;
                    done_i    = 1'b1;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack || tmo_hit) begin
                    state_nxt = ST_RESP_D;
                    done_d    = 1'b1;
                end
            end
            ST_RESP_I: state_nxt = ST_IDLE;
            ST_RESP_D: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Round-robin history; starts at 1 so the first tie goes to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       last_d <= 1'b1;
        else if (grant_i) last_d <= 1'b0;
        else if (grant_d) last_d <= 1'b1;
    end

    // Request latch; the memory bus is driven only from these registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_i) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end
    end

    // Watchdog: counts BUSY cycles, cleared whenever the arbiter is not busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (mem_req && (state_nxt == state))
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Response capture; writes and aborted accesses return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
            err_q    <= 1'b0;
        end else if (done_i) begin
            if_rdata <= tmo_hit ? '0 : mem_rdata;
            err_q    <= tmo_hit;
        end else if (done_d) begin
            d_rdata  <= (tmo_hit || mem_we) ? '0 : mem_rdata;
            err_q    <= tmo_hit;
        end
    end

    assign mem_req  = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign if_ready = (state == ST_RESP_I);
    assign d_ready  = (state == ST_RESP_D);
    assign err      = err_q && (if_ready || d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [16:0] if_addr;
    logic [16:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [16:0] d_addr;
    logic [16:0] d_wdata;
    logic [16:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [16:0] mem_wdata;
    logic [16:0] mem_rdata;
    logic        mem_ack;

    int checks;
    int errors;

    mem_arbiter #(.AW(17), .DW(17), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_mem_req",  32'(mem_req),  32'h0);
        chk("rst_mem_we",   32'(mem_we),   32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wd",   32'(mem_wdata),32'h0);
        chk("rst_if_ready", 32'(if_ready), 32'h0);
        chk("rst_d_ready",  32'(d_ready),  32'h0);
        chk("rst_if_rdata", 32'(if_rdata), 32'h0);
        chk("rst_d_rdata",  32'(d_rdata),  32'h0);
        chk("rst_err",      32'(err),      32'h0);
        reset = 1'b1;
        step();

        // Tie after reset: fetch first, data 3 cycles later
        if_req  = 1'b1; if_addr = 17'h00040;
        d_req   = 1'b1; d_we = 1'b0; d_addr = 17'h00123;
        step();
        chk("tie_busy_i_req",  32'(mem_req),  32'h1);
        chk("tie_busy_i_addr", 32'(mem_addr), 32'h00040);
        chk("tie_busy_i_we",   32'(mem_we),   32'h0);
        mem_ack = 1'b1; mem_rdata = 17'h0AAAA;
        step();
        chk("tie_if_ready", 32'(if_ready), 32'h1);
        chk("tie_if_rdata", 32'(if_rdata), 32'h0AAAA);
        chk("tie_d_ready0", 32'(d_ready),  32'h0);
        if_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("tie_idle_req", 32'(mem_req), 32'h0);
        step();
        chk("tie_busy_d_addr", 32'(mem_addr), 32'h00123);
        mem_ack = 1'b1; mem_rdata = 17'h01111;
        step();
        chk("tie_d_ready",  32'(d_ready), 32'h1);
        chk("tie_d_rdata",  32'(d_rdata), 32'h01111);
        chk("tie_if_ready0",32'(if_ready),32'h0);
        d_req = 1'b0; mem_ack = 1'b0;
        step();

        // Single fetch
        if_req = 1'b1; if_addr = 17'h00010;
        step();
        chk("sf_mem_req",  32'(mem_req),  32'h1);
        chk("sf_mem_addr", 32'(mem_addr), 32'h00010);
        chk("sf_ready_early", 32'(if_ready), 32'h0);
        mem_ack = 1'b1; mem_rdata = 17'h1A2B3;
        step();
        chk("sf_if_ready", 32'(if_ready), 32'h1);
        chk("sf_if_rdata", 32'(if_rdata), 32'h1A2B3);
        chk("sf_err",      32'(err),      32'h0);
        if_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("sf_idle_ready", 32'(if_ready), 32'h0);
        chk("sf_idle_req",   32'(mem_req),  32'h0);

        // Data write with ack in the fifth BUSY cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 17'h1FFFF; d_wdata = 17'h15555;
        mem_rdata = 17'h0BEEF;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("wr_mem_req",   32'(mem_req),   32'h1);
            chk("wr_mem_we",    32'(mem_we),    32'h1);
            chk("wr_mem_addr",  32'(mem_addr),  32'h1FFFF);
            chk("wr_mem_wdata", 32'(mem_wdata), 32'h15555);
            chk("wr_d_ready0",  32'(d_ready),   32'h0);
            if (i == 4) mem_ack = 1'b1;
            step();
        end
        chk("wr_d_ready", 32'(d_ready), 32'h1);
        chk("wr_d_rdata", 32'(d_rdata), 32'h0);
        chk("wr_err",     32'(err),     32'h0);
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        step();

        // Timeout: data read that never acks
        d_req = 1'b1; d_addr = 17'h00200; mem_rdata = 17'h1FFFF;
        step();
        for (int i = 1; i <= 16; i++) begin
            chk("to_mem_req",  32'(mem_req), 32'h1);
            chk("to_d_ready0", 32'(d_ready), 32'h0);
            step();
        end
        chk("to_d_ready", 32'(d_ready), 32'h1);
        chk("to_err",     32'(err),     32'h1);
        chk("to_d_rdata", 32'(d_rdata), 32'h0);
        d_req = 1'b0;
        step();
        mem_ack = 1'b1;
        step();
        chk("stray_mem_req", 32'(mem_req), 32'h0);
        chk("stray_d_ready", 32'(d_ready), 32'h0);
        chk("stray_if_ready",32'(if_ready),32'h0);
        chk("stray_err",     32'(err),     32'h0);
        mem_ack = 1'b0;

        // Fairness: both held, grants alternate starting with fetch
        if_req = 1'b1; if_addr = 17'h00300;
        d_req  = 1'b1; d_addr  = 17'h00400; d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_mem_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h00300 : 32'h00400);
            mem_ack = 1'b1; mem_rdata = 17'(17'h00500 + i);
            step();
            chk("rr_if_ready", 32'(if_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_d_ready",  32'(d_ready),  (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_rdata", (i % 2 == 0) ? 32'(if_rdata) : 32'(d_rdata), 32'h00500 + 32'(i));
            mem_ack = 1'b0;
            if (i == 5) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            step();
        end
        chk("rr_done_idle", 32'(mem_req), 32'h0);

        // Reset mid-access during BUSY_D
        d_req = 1'b1; d_addr = 17'h00600;
        step();
        chk("rm_busy_d", 32'(mem_req),  32'h1);
        chk("rm_addr",   32'(mem_addr), 32'h00600);
        if_req = 1'b1; if_addr = 17'h00700;
        #2;
        reset = 1'b0;
        #1;
        chk("rm_async_drop", 32'(mem_req), 32'h0);
        step();
        chk("rm_no_d_ready",  32'(d_ready),  32'h0);
        chk("rm_no_if_ready", 32'(if_ready), 32'h0);
        reset = 1'b1;
        step();
        chk("rm_grant_i_req",  32'(mem_req),  32'h1);
        chk("rm_grant_i_addr", 32'(mem_addr), 32'h00700);
        mem_ack = 1'b1; mem_rdata = 17'h00777;
        step();
        chk("rm_if_ready", 32'(if_ready), 32'h1);
        chk("rm_if_rdata", 32'(if_rdata), 32'h00777);
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
